// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if: implicit-access lanes between the trap sequencer and the CSR file
interface trap_sequencer_if;
  logic [127:0] impl_csr;
  logic [47:0]  impl_addrs_r;
  logic [3:0]   impl_read_enable;
  logic [47:0]  impl_addrs_w;
  logic [3:0]   impl_write_enable;
  logic [127:0] impl_write_data;
  modport master (
    input  impl_csr,
    output impl_addrs_r, impl_read_enable, impl_addrs_w, impl_write_enable, impl_write_data
  );
  modport slave (
    output impl_csr,
    input  impl_addrs_r, impl_read_enable, impl_addrs_w, impl_write_enable, impl_write_data
  );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences M-mode trap entry and MRET over the CSR implicit-access lanes
module trap_sequencer #(
  parameter logic [1:0] RESET_MODE  = 2'b11,
  parameter bit         VECTORED_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trap_req,
  input  logic [31:0]              trap_cause,
  input  logic [31:0]              trap_pc,
  input  logic [31:0]              trap_tval,
  input  logic                     mret_req,
  trap_sequencer_if.master         impl,
  output logic                     busy,
  output logic                     trap_ack,
  output logic                     mret_ack,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic [1:0]               mode
);
  typedef enum logic [2:0] {IDLE, T_RD, T_WR, M_RD, M_WR, REDIR} state_t;
  state_t      state;
  logic [31:0] cause_q, pc_q, tval_q, tgt;
  logic [1:0]  mpp_q;
  logic [31:0] csr0, csr1, trap_ms, mret_ms, trap_tgt, mret_tgt;
  logic        vec;
  // derive next mstatus and redirect targets from the lanes being read this cycle
  always_comb begin
    csr0     = impl.impl_csr[31:0];
    csr1     = impl.impl_csr[63:32];
    trap_ms  = csr1;
    trap_ms[7]     = csr1[3];
    trap_ms[3]     = 1'b0;
    trap_ms[12:11] = mode;
    mret_ms  = csr1;
    mret_ms[3]     = csr1[7];
    mret_ms[7]     = 1'b1;
    mret_ms[12:11] = 2'b00;
    vec      = VECTORED_EN && csr0[1:0] == 2'b01 && cause_q[31];
    trap_tgt = {csr0[31:2], 2'b00} + (vec ? {cause_q[29:0], 2'b00} : 32'h0);
    mret_tgt = {csr0[31:1], 1'b0};
  end
  // sequencer FSM with registered lane, handshake and privilege outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      busy                   <= 1'b0;
      trap_ack               <= 1'b0;
      mret_ack               <= 1'b0;
      redirect_valid         <= 1'b0;
      redirect_pc            <= '0;
      mode                   <= RESET_MODE;
      impl.impl_addrs_r      <= '0;
      impl.impl_read_enable  <= '0;
      impl.impl_addrs_w      <= '0;
      impl.impl_write_enable <= '0;
      impl.impl_write_data   <= '0;
      cause_q                <= '0;
      pc_q                   <= '0;
      tval_q                 <= '0;
      tgt                    <= '0;
      mpp_q                  <= '0;
    end else begin
      trap_ack               <= 1'b0;
      mret_ack               <= 1'b0;
      redirect_valid         <= 1'b0;
      impl.impl_addrs_r      <= '0;
      impl.impl_read_enable  <= '0;
      impl.impl_addrs_w      <= '0;
      impl.impl_write_enable <= '0;
      impl.impl_write_data   <= '0;
      case (state)
        IDLE: begin
          if (trap_req) begin
            state                 <= T_RD;
            busy                  <= 1'b1;
            cause_q               <= trap_cause;
            pc_q                  <= trap_pc;
            tval_q                <= trap_tval;
            impl.impl_read_enable <= 4'b0011;
            impl.impl_addrs_r     <= {24'h0, 12'h300, 12'h305};
          end else if (mret_req) begin
            state                 <= M_RD;
            busy                  <= 1'b1;
            impl.impl_read_enable <= 4'b0011;
            impl.impl_addrs_r     <= {24'h0, 12'h300, 12'h341};
          end
        end
        T_RD: begin
          state                  <= T_WR;
          tgt                    <= trap_tgt;
          impl.impl_write_enable <= 4'b1111;
          impl.impl_addrs_w      <= {12'h300, 12'h343, 12'h342, 12'h341};
          impl.impl_write_data   <= {trap_ms, tval_q, cause_q, pc_q & ~32'h3};
        end
        M_RD: begin
          state                  <= M_WR;
          tgt                    <= mret_tgt;
          mpp_q                  <= csr1[12:11];
          impl.impl_write_enable <= 4'b1000;
          impl.impl_addrs_w      <= {12'h300, 36'h0};
          impl.impl_write_data   <= {mret_ms, 96'h0};
        end
        T_WR: begin
          state          <= REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= tgt;
          trap_ack       <= 1'b1;
          mode           <= 2'b11;
        end
        M_WR: begin
          state          <= REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= tgt;
          mret_ack       <= 1'b1;
          mode           <= mpp_q == 2'b10 ? 2'b00 : mpp_q;
        end
        REDIR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed checks of trap entry, MRET, vectoring, arbitration and reset abort
module tb_trap_sequencer;
  logic        clk = 1'b0;
  logic        reset, trap_req, mret_req;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        busy, trap_ack, mret_ack, redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  mode;
  logic [31:0] mtvec_v, mstatus_v, mepc_v;
  int          total = 0;
  int          fails = 0;
  trap_sequencer_if bus();
  trap_sequencer dut (
    .clk(clk), .reset(reset), .trap_req(trap_req), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_req(mret_req), .impl(bus),
    .busy(busy), .trap_ack(trap_ack), .mret_ack(mret_ack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mode(mode)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] csr_rd(input logic [11:0] a);
    return a == 12'h305 ? mtvec_v : a == 12'h300 ? mstatus_v : a == 12'h341 ? mepc_v : 32'h0;
  endfunction
  // CSR file model: combinational read per enabled lane
  always_comb begin
    bus.impl_csr = '0;
    for (int i = 0; i < 4; i++)
      bus.impl_csr[32*i +: 32] = bus.impl_read_enable[i] ? csr_rd(bus.impl_addrs_r[12*i +: 12]) : 32'h0;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_trap(input logic [31:0] c, p, v, exp_pc, input logic [127:0] wd);
    trap_cause = c; trap_pc = p; trap_tval = v; trap_req = 1'b1;
    tick;
    chk("t_busy", busy, 1);
    chk("t_rd_en", bus.impl_read_enable, 4'b0011);
    chk("t_rd_addr", bus.impl_addrs_r, 48'h000000300305);
    tick;
    chk("t_wr_en", bus.impl_write_enable, 4'hF);
    chk("t_wr_addr", bus.impl_addrs_w, 48'h300343342341);
    chk("t_wr_data", bus.impl_write_data, wd);
    tick;
    chk("t_ack", trap_ack, 1);
    chk("t_no_mret_ack", mret_ack, 0);
    chk("t_redir_v", redirect_valid, 1);
    chk("t_redir_pc", redirect_pc, exp_pc);
    chk("t_mode", mode, 2'b11);
    trap_req = 1'b0;
    tick;
    chk("t_idle", busy, 0);
    chk("t_ack_pulse", trap_ack, 0);
  endtask
  task automatic do_mret(input logic [31:0] exp_ms, exp_pc, input logic [1:0] exp_mode);
    mret_req = 1'b1;
    tick;
    chk("m_busy", busy, 1);
    chk("m_rd_en", bus.impl_read_enable, 4'b0011);
    chk("m_rd_addr", bus.impl_addrs_r, 48'h000000300341);
    tick;
    chk("m_wr_en", bus.impl_write_enable, 4'b1000);
    chk("m_wr_addr", bus.impl_addrs_w, 48'h300000000000);
    chk("m_wr_data", bus.impl_write_data, {exp_ms, 96'h0});
    tick;
    chk("m_ack", mret_ack, 1);
    chk("m_no_trap_ack", trap_ack, 0);
    chk("m_redir_v", redirect_valid, 1);
    chk("m_redir_pc", redirect_pc, exp_pc);
    chk("m_mode", mode, exp_mode);
    mret_req = 1'b0;
    tick;
    chk("m_idle", busy, 0);
    chk("m_ack_pulse", mret_ack, 0);
  endtask
  initial begin
    reset = 1'b1; trap_req = 1'b0; mret_req = 1'b0;
    trap_cause = '0; trap_pc = '0; trap_tval = '0;
    mtvec_v = 32'h1000; mstatus_v = 32'h8; mepc_v = 32'h404;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_mode", mode, 2'b11);
    chk("rst_en", {bus.impl_read_enable, bus.impl_write_enable}, 8'h00);
    chk("rst_redir", {redirect_valid, trap_ack, mret_ack}, 3'b000);
    chk("rst_pc", redirect_pc, 32'h0);
    chk("rst_addrs", {bus.impl_addrs_r, bus.impl_addrs_w}, 96'h0);
    reset = 1'b0;
    tick;
    trap_cause = 32'h2; trap_pc = 32'h204; trap_tval = 32'hDEAD; trap_req = 1'b1;
    tick;
    tick;
    chk("abort_pre_wr_en", bus.impl_write_enable, 4'hF);
    #1 reset = 1'b1;
    #1;
    chk("abort_wr_en", bus.impl_write_enable, 4'h0);
    chk("abort_wr_addr", bus.impl_addrs_w, 48'h0);
    chk("abort_busy", busy, 0);
    trap_req = 1'b0;
    tick;
    reset = 1'b0;
    tick;
    tick;
    chk("abort_no_ack", {trap_ack, redirect_valid}, 2'b00);
    chk("abort_mode", mode, 2'b11);
    mstatus_v = 32'h80; mepc_v = 32'h404;
    do_mret(32'h88, 32'h404, 2'b00);
    mtvec_v = 32'h1000; mstatus_v = 32'h8;
    do_trap(32'h2, 32'h204, 32'hDEAD, 32'h1000, {32'h80, 32'hDEAD, 32'h2, 32'h204});
    mtvec_v = 32'h1001;
    do_trap(32'h8000_0007, 32'h207, 32'h0, 32'h101C, {32'h1880, 32'h0, 32'h8000_0007, 32'h204});
    do_trap(32'h5, 32'h300, 32'h1, 32'h1000, {32'h1880, 32'h1, 32'h5, 32'h300});
    mtvec_v = 32'h1002;
    do_trap(32'h8000_0007, 32'h208, 32'h0, 32'h1000, {32'h1880, 32'h0, 32'h8000_0007, 32'h208});
    mtvec_v = 32'hFFFF_FFF1;
    do_trap(32'h8000_0003, 32'h0, 32'h0, 32'hFFFF_FFFC, {32'h1880, 32'h0, 32'h8000_0003, 32'h0});
    do_trap(32'h8000_0005, 32'h0, 32'h0, 32'h0000_0004, {32'h1880, 32'h0, 32'h8000_0005, 32'h0});
    mstatus_v = 32'h1000; mepc_v = 32'h404;
    do_mret(32'h80, 32'h404, 2'b00);
    mtvec_v = 32'h2000; mstatus_v = 32'h880; mepc_v = 32'h407;
    mret_req = 1'b1;
    do_trap(32'hB, 32'h100, 32'h0, 32'h2000, {32'h0, 32'h0, 32'hB, 32'h100});
    do_mret(32'h88, 32'h406, 2'b01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, fails);
    $finish;
  end
endmodule
